// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: instruction-address generator with stall, redirect, halt and retire counting
module pc_fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] STEP = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 68,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              misalign_err
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;
  logic err_n;
  assign cnt_inc = &retire_cnt ? retire_cnt : retire_cnt + 1'b1;
  // next state and next register values; RUN decisions follow halt > stall > misalign > redirect > max > step
  always_comb begin
    state_n = state;
    pc_n = pc_o;
    cnt_n = retire_cnt;
    err_n = misalign_err;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN:
        if (halt_req) state_n = HALT;
        else if (!stall) begin
          if (redirect_valid && redirect_addr[1:0] != 2'b00) begin
            err_n = 1'b1;
            state_n = HALT;
          end else begin
            cnt_n = cnt_inc;
            if (redirect_valid) pc_n = redirect_addr;
            else if (pc_o == MAX_ADDR) state_n = HALT;
            else pc_n = pc_o + STEP;
          end
        end
      HALT:
        if (start) begin
          state_n = RUN;
          pc_n = RESET_ADDR;
          cnt_n = '0;
          err_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_o <= RESET_ADDR;
      valid_o <= 1'b0;
      halted_o <= 1'b0;
      retire_cnt <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_n;
      pc_o <= pc_n;
      valid_o <= state_n == RUN;
      halted_o <= state_n == HALT;
      retire_cnt <= cnt_n;
      misalign_err <= err_n;
    end
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: scoreboard bench for default and wrap/saturate configurations
module tb_pc_fetch_sequencer;
  logic clk = 0, rst = 1, start = 0, stall = 0, halt_req = 0, redirect_valid = 0;
  logic [31:0] redirect_addr = 0;
  logic [31:0] pc0, pc1;
  logic v0, h0, e0, v1, h1, e1;
  logic [15:0] c0;
  logic [1:0] c1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer u0 (.clk(clk), .rst(rst), .start(start), .stall(stall), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .pc_o(pc0), .valid_o(v0),
    .halted_o(h0), .retire_cnt(c0), .misalign_err(e0));

  pc_fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFF8), .MAX_ADDR(32'd8), .CNT_W(2)) u1 (.clk(clk), .rst(rst),
    .start(start), .stall(stall), .halt_req(halt_req), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .pc_o(pc1), .valid_o(v1), .halted_o(h1), .retire_cnt(c1),
    .misalign_err(e1));

  // mode: 0 idle, 1 running, 2 halted
  typedef struct packed {logic [1:0] mode; logic [31:0] pc; logic [31:0] cnt; logic err;} mdl_t;
  typedef struct packed {mdl_t a; mdl_t b;} exp_t;
  mdl_t m0, m1;
  exp_t q[$];

  function automatic mdl_t mreset(logic [31:0] ra0);
    mdl_t m;
    m.mode = 0; m.pc = ra0; m.cnt = 0; m.err = 0;
    return m;
  endfunction

  function automatic mdl_t nxt(mdl_t m, bit s, bit stl, bit h, bit rv, logic [31:0] ra,
                               logic [31:0] ra0, logic [31:0] mx, int cmax);
    mdl_t r = m;
    int unsigned bumped = (m.cnt < cmax) ? m.cnt + 1 : m.cnt;
    if (m.mode == 0) begin
      if (s) r.mode = 1;
    end else if (m.mode == 2) begin
      if (s) begin r.mode = 1; r.pc = ra0; r.cnt = 0; r.err = 0; end
    end else if (h) r.mode = 2;
    else if (stl) r = m;
    else if (rv && (ra % 4) != 0) begin r.err = 1; r.mode = 2; end
    else if (rv) begin r.pc = ra; r.cnt = bumped; end
    else if (m.pc == mx) begin r.cnt = bumped; r.mode = 2; end
    else begin r.pc = m.pc + 32'd4; r.cnt = bumped; end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: compares every cycle's registered outputs against the queued prediction
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("u0 pc", pc0, e.a.pc);
      chk("u0 valid", {31'b0, v0}, {31'b0, e.a.mode == 1});
      chk("u0 halted", {31'b0, h0}, {31'b0, e.a.mode == 2});
      chk("u0 cnt", {16'b0, c0}, e.a.cnt);
      chk("u0 err", {31'b0, e0}, {31'b0, e.a.err});
      chk("u1 pc", pc1, e.b.pc);
      chk("u1 valid", {31'b0, v1}, {31'b0, e.b.mode == 1});
      chk("u1 halted", {31'b0, h1}, {31'b0, e.b.mode == 2});
      chk("u1 cnt", {30'b0, c1}, e.b.cnt);
      chk("u1 err", {31'b0, e1}, {31'b0, e.b.err});
    end
  end

  task automatic drive(bit s, bit stl, bit h, bit rv, logic [31:0] ra);
    @(negedge clk);
    start = s; stall = stl; halt_req = h; redirect_valid = rv; redirect_addr = ra;
    m0 = nxt(m0, s, stl, h, rv, ra, 32'h0, 32'd68, 65535);
    m1 = nxt(m1, s, stl, h, rv, ra, 32'hFFFF_FFF8, 32'd8, 3);
    q.push_back('{m0, m1});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 0; stall = 0; halt_req = 0; redirect_valid = 0;
    rst = 1;
    #1;
    chk("rst pc", pc0, 32'h0);
    chk("rst valid", {31'b0, v0}, 32'h0);
    chk("rst halted", {31'b0, h0}, 32'h0);
    chk("rst cnt", {16'b0, c0}, 32'h0);
    chk("rst err", {31'b0, e0}, 32'h0);
    chk("rst pc1", pc1, 32'hFFFF_FFF8);
    m0 = mreset(32'h0);
    m1 = mreset(32'hFFFF_FFF8);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    m0 = mreset(32'h0);
    m1 = mreset(32'hFFFF_FFF8);
    @(negedge clk);
    chk("init pc", pc0, 32'h0);
    chk("init valid", {31'b0, v0}, 32'h0);
    chk("init cnt", {16'b0, c0}, 32'h0);
    rst = 0;
    idle();
    drive(0, 1, 1, 1, 32'h40);
    settle();
    chk("idle ignores", pc0, 32'h0);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("start pc", pc0, 32'h0);
    chk("start valid", {31'b0, v0}, 32'h1);
    for (int i = 0; i < 30 && m0.mode != 2; i++) idle();
    settle();
    chk("line pc", pc0, 32'd68);
    chk("line halted", {31'b0, h0}, 32'h1);
    chk("line valid", {31'b0, v0}, 32'h0);
    chk("line cnt", {16'b0, c0}, 32'd18);
    chk("wrap pc", pc1, 32'd8);
    chk("wrap sat", {30'b0, c1}, 32'd3);
    chk("wrap halted", {31'b0, h1}, 32'h1);
    drive(1, 0, 0, 0, 0);
    repeat (3) idle();
    repeat (3) drive(0, 1, 0, 0, 0);
    settle();
    chk("stall pc", pc0, 32'd12);
    chk("stall cnt", {16'b0, c0}, 32'd3);
    idle();
    settle();
    chk("post stall pc", pc0, 32'd16);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) idle();
    drive(0, 1, 0, 1, 32'h40);
    settle();
    chk("stall beats redirect", pc0, 32'd8);
    drive(0, 0, 0, 1, 32'h40);
    settle();
    chk("redirect pc", pc0, 32'h40);
    idle();
    settle();
    chk("after redirect", pc0, 32'h44);
    drive(0, 0, 0, 1, 32'h10);
    settle();
    chk("redirect at max", pc0, 32'h10);
    chk("no halt at max", {31'b0, h0}, 32'h0);
    idle();
    drive(0, 0, 0, 1, 32'h22);
    settle();
    chk("misalign err", {31'b0, e0}, 32'h1);
    chk("misalign halt", {31'b0, h0}, 32'h1);
    chk("misalign pc", pc0, 32'd20);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("restart err", {31'b0, e0}, 32'h0);
    chk("restart pc", pc0, 32'h0);
    repeat (6) idle();
    drive(0, 0, 1, 0, 0);
    settle();
    chk("halt_req pc", pc0, 32'd24);
    chk("halt_req halted", {31'b0, h0}, 32'h1);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("restart cnt", {16'b0, c0}, 32'h0);
    repeat (9) idle();
    settle();
    chk("pre reset pc", pc0, 32'd36);
    async_reset();
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else begin
        logic [31:0] ra = $urandom_range(0, 31) * 4;
        if ($urandom_range(0, 7) == 0) ra = ra + $urandom_range(1, 3);
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 4) == 0, ra);
      end
    end
    idle();
    repeat (3) settle();
    chk("queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
